// File: rtl/spwm_pkg.sv
// Shared constants for the SPWM generator/decoder pair: state codes, default width
// and polarity encoding.
package spwm_pkg;

  // Matches the generator's 10-bit signal width.
  localparam int unsigned SPWM_WIDTH = 10;

  typedef logic [0:0] dec_state_t;
  localparam dec_state_t ST_IDLE = 1'b0;
  localparam dec_state_t ST_RUN  = 1'b1;

  // Same meaning as the generator's modo bit.
  localparam logic POL_POS = 1'b1;
  localparam logic POL_NEG = 1'b0;

endpackage

// File: rtl/spwm_sync.sv
// Multi-flop synchronizer for one SPWM leg, async active-low reset.
module spwm_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spwm_decoder.sv
// Recovers amplitude and polarity from the two SPWM legs by counting each leg's high
// time over a 2^PERIOD_LOG2-cycle window; flags zero crossings and leg overlap.
module spwm_decoder
  import spwm_pkg::*;
#(
  parameter int unsigned PERIOD_LOG2 = SPWM_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   spwm_p,
  input  logic                   spwm_n,
  input  logic                   fault_clr,
  output logic [PERIOD_LOG2-1:0] sample,
  output logic                   polarity,
  output logic                   sample_valid,
  output logic                   zero_cross,
  output logic                   fault
);

  localparam int unsigned CW = PERIOD_LOG2 + 1;

  logic p_s, n_s;

  spwm_sync #(.STAGES(SYNC_STAGES)) u_sync_p (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spwm_p),
    .q     (p_s)
  );

  spwm_sync #(.STAGES(SYNC_STAGES)) u_sync_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spwm_n),
    .q     (n_s)
  );

  dec_state_t             state_q;
  logic [PERIOD_LOG2-1:0] win_cnt_q;
  logic [CW-1:0]          cnt_p_q, cnt_n_q;
  logic                   ovl_q;
  logic [PERIOD_LOG2-1:0] sample_q;
  logic                   polarity_q;
  logic                   sample_valid_q;
  logic                   zero_cross_q;
  logic                   fault_q;

  logic [PERIOD_LOG2-1:0] win_pos;
  logic                   win_last;
  logic [CW-1:0]          cnt_p_inc, cnt_n_inc;
  logic                   ovl_inc;
  logic [PERIOD_LOG2-1:0] sat_p, sat_n;
  logic [PERIOD_LOG2-1:0] new_sample;
  logic                   new_pol;
  logic                   win_end_ok;
  logic                   win_end_ovl;

  always_comb begin
    win_pos   = (state_q == ST_RUN) ? win_cnt_q : '0;
    win_last  = (win_pos == '1);
    // Include the current cycle's legs so the final window cycle is counted.
    cnt_p_inc = cnt_p_q + CW'(p_s);
    cnt_n_inc = cnt_n_q + CW'(n_s);
    ovl_inc   = ovl_q | (p_s & n_s);
    sat_p     = cnt_p_inc[PERIOD_LOG2] ? '1 : cnt_p_inc[PERIOD_LOG2-1:0];
    sat_n     = cnt_n_inc[PERIOD_LOG2] ? '1 : cnt_n_inc[PERIOD_LOG2-1:0];

    new_sample = '0;
    new_pol    = polarity_q;
    if (cnt_p_inc > cnt_n_inc) begin
      new_sample = sat_p;
      new_pol    = POL_POS;
    end else if (cnt_n_inc > cnt_p_inc) begin
      new_sample = sat_n;
      new_pol    = POL_NEG;
    end

    win_end_ok  = en & win_last & ~ovl_inc;
    win_end_ovl = en & win_last & ovl_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      cnt_p_q   <= '0;
      cnt_n_q   <= '0;
      ovl_q     <= 1'b0;
    end else if (!en) begin
      // Dropping en discards the partial window.
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      cnt_p_q   <= '0;
      cnt_n_q   <= '0;
      ovl_q     <= 1'b0;
    end else begin
      state_q   <= ST_RUN;
      win_cnt_q <= win_pos + PERIOD_LOG2'(1);
      if (win_last) begin
        cnt_p_q <= '0;
        cnt_n_q <= '0;
        ovl_q   <= 1'b0;
      end else begin
        cnt_p_q <= cnt_p_inc;
        cnt_n_q <= cnt_n_inc;
        ovl_q   <= ovl_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q       <= '0;
      polarity_q     <= POL_NEG;
      sample_valid_q <= 1'b0;
      zero_cross_q   <= 1'b0;
    end else begin
      sample_valid_q <= win_end_ok;
      zero_cross_q   <= win_end_ok & (new_pol != polarity_q);
      if (win_end_ok) begin
        sample_q   <= new_sample;
        polarity_q <= new_pol;
      end
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (win_end_ovl) begin
      fault_q <= 1'b1;
    end else if (fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  assign sample       = sample_q;
  assign polarity     = polarity_q;
  assign sample_valid = sample_valid_q;
  assign zero_cross   = zero_cross_q;
  assign fault        = fault_q;

endmodule
